// File: rtl/spi_frame_scheduler_if.sv
// Bus between the frame scheduler, the frame buffer read port and the SPI sender.
// The slave modport is the scheduler's side of the bus.
interface spi_frame_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  start_in;
    logic                  continuous_in;
    logic                  abort_in;
    logic [DATA_WIDTH-1:0] pixel_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  trigger_out;
    logic                  spi_hsync_out;
    logic                  spi_vsync_out;
    logic                  busy_out;
    logic                  frame_done_out;
    logic [15:0]           hcount_out;
    logic [15:0]           vcount_out;

    modport master (
        output start_in, continuous_in, abort_in, pixel_in,
        input  addr_out, data_out, trigger_out, spi_hsync_out, spi_vsync_out,
               busy_out, frame_done_out, hcount_out, vcount_out
    );

    modport slave (
        input  start_in, continuous_in, abort_in, pixel_in,
        output addr_out, data_out, trigger_out, spi_hsync_out, spi_vsync_out,
               busy_out, frame_done_out, hcount_out, vcount_out
    );
endinterface

// File: rtl/spi_frame_scheduler.sv
// Streams a frame from a synchronous-read buffer into the SPI sender, one pixel
// per fixed-length slot, with hsync/vsync framing and an idle gap after each row.
//
// state | meaning
// IDLE  | waiting for start_in
// FETCH | first pixel of a frame in flight from the buffer
// SEND  | one-cycle trigger to the sender, slot begins
// HOLD  | rest of the slot; next pixel is prefetched
// GAP   | idle cycles between rows (and between frames in continuous mode)
// DRAIN | one-cycle frame_done pulse, address wraps to 0
module spi_frame_scheduler #(
    parameter int H_PIXELS     = 320,
    parameter int V_PIXELS     = 180,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int TX_CYCLES    = 16,
    parameter int LINE_GAP     = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    spi_frame_scheduler_if.slave bus
);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, HOLD, GAP, DRAIN} state_t;

    localparam logic [15:0] HOLD_LOAD     = 16'(TX_CYCLES - 2);
    localparam logic [15:0] GAP_LOAD      = 16'(LINE_GAP - 1);
    // DRAIN already spends one of the inter-frame gap cycles
    localparam logic [15:0] GAP_LOAD_WRAP = 16'(LINE_GAP - 2);
    localparam logic [15:0] H_LAST        = 16'(H_PIXELS - 1);
    localparam logic [15:0] V_LAST        = 16'(V_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state, state_nxt;
    logic [15:0]             timer;
    logic [15:0]             hcount, vcount;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   hold_q, data_q;
    logic [READ_LATENCY:0]   rd_pipe;
    logic                    abort_q, abort_now, capture;
    logic                    row_end, frame_end, issue;

    assign abort_now = abort_q | bus.abort_in;
    assign capture   = rd_pipe[READ_LATENCY];
    assign row_end   = (hcount == H_LAST);
    assign frame_end = row_end && (vcount == V_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_in && !bus.abort_in) begin
                    state_nxt = FETCH;
                    issue     = 1'b1;
                end
            end
            FETCH: begin
                if (abort_now)    state_nxt = IDLE;
                else if (capture) state_nxt = SEND;
            end
            SEND: begin
                state_nxt = HOLD;
                issue     = !frame_end;
            end
            HOLD: begin
                if (timer == 16'd0) begin
                    if (abort_now) begin
                        state_nxt = IDLE;
                    end else if (frame_end) begin
                        state_nxt = DRAIN;
                        issue     = 1'b1;
                    end else if (row_end) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            GAP: begin
                if (abort_now)            state_nxt = IDLE;
                else if (timer == 16'd0)  state_nxt = SEND;
            end
            DRAIN: begin
                if (bus.continuous_in && !abort_now) state_nxt = GAP;
                else                                 state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            timer   <= '0;
            hcount  <= '0;
            vcount  <= '0;
            addr    <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            rd_pipe <= '0;
            abort_q <= 1'b0;
        end else begin
            // Stale reads from an aborted frame must not complete a new FETCH
            if (state == IDLE) rd_pipe <= {{READ_LATENCY{1'b0}}, issue};
            else               rd_pipe <= {rd_pipe[READ_LATENCY-1:0], issue};

            if (issue) begin
                if (state == SEND) addr <= addr + ADDR_ONE;
                else               addr <= '0;
            end

            if (capture) hold_q <= bus.pixel_in;

            if (state_nxt == IDLE)                  abort_q <= 1'b0;
            else if (state != IDLE && bus.abort_in) abort_q <= 1'b1;

            if (state == SEND)                              timer <= HOLD_LOAD;
            else if (state == HOLD && state_nxt == GAP)     timer <= GAP_LOAD;
            else if (state == DRAIN && state_nxt == GAP)    timer <= GAP_LOAD_WRAP;
            else if (timer != 16'd0)                        timer <= timer - 16'd1;

            if (state_nxt == SEND && state != SEND) begin
                data_q <= capture ? bus.pixel_in : hold_q;
                if (state == FETCH || row_end && vcount == V_LAST) begin
                    hcount <= '0;
                    vcount <= '0;
                end else if (row_end) begin
                    hcount <= '0;
                    vcount <= vcount + 16'd1;
                end else begin
                    hcount <= hcount + 16'd1;
                end
            end
        end
    end

    assign bus.addr_out       = addr;
    assign bus.data_out       = data_q;
    assign bus.trigger_out    = (state == SEND);
    assign bus.spi_hsync_out  = (state == SEND || state == HOLD) && (hcount == 16'd0);
    assign bus.spi_vsync_out  = bus.spi_hsync_out && (vcount == 16'd0);
    assign bus.busy_out       = (state != IDLE);
    assign bus.frame_done_out = (state == DRAIN);
    assign bus.hcount_out     = hcount;
    assign bus.vcount_out     = vcount;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Bench for spi_frame_scheduler on a 4x2 frame; buffer model returns address+0x10
// after two cycles, expected triggers are queued when a frame is started.
module tb_spi_frame_scheduler;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int RL   = 2;
    localparam int TX   = 8;
    localparam int GAPC = 4;
    localparam int FIRST = RL + 2;
    localparam int ROW   = H * TX + GAPC;
    localparam int FRAME = FIRST + (V - 1) * ROW + H * TX;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk = ~clk;

    spi_frame_scheduler_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    spi_frame_scheduler #(
        .H_PIXELS(H), .V_PIXELS(V), .DATA_WIDTH(8), .ADDR_WIDTH(16),
        .READ_LATENCY(RL), .TX_CYCLES(TX), .LINE_GAP(GAPC)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .bus(bus)
    );

    logic [7:0] rd1;
    always @(posedge clk) begin
        rd1          <= 8'(bus.addr_out + 16'h10);
        bus.pixel_in <= rd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int data; int h; int v; int hs; int vs; } trig_t;
    typedef struct { string name; bit cont; int start2_at; int abort_at; int len;
                     int n_trig; int done_at; int busy_fall; } scen_t;
    typedef struct { int cyc; int busy; int hs; int vs; int done; int h; int v; } probe_t;

    trig_t  exp_trig[$];
    int     exp_done[$];
    scen_t  scen[4];
    probe_t probes[11];

    int n_chk = 0;
    int n_err = 0;
    int t0 = 0;
    int trig_seen = 0;
    int rel;
    bit prev_trig = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_frame(input int cutoff, input bit cont);
        trig_t e;
        for (int f = 0; f < 2; f++) begin
            if (f == 0 || cont) begin
                for (int v = 0; v < V; v++) begin
                    for (int h = 0; h < H; h++) begin
                        e.cyc  = f * FRAME + FIRST + v * ROW + h * TX;
                        e.data = 16'h10 + v * H + h;
                        e.h    = h;
                        e.v    = v;
                        e.hs   = (h == 0) ? 1 : 0;
                        e.vs   = (h == 0 && v == 0) ? 1 : 0;
                        if (e.cyc <= cutoff) exp_trig.push_back(e);
                    end
                end
            end
        end
    endtask

    // Scoreboard side: every trigger and done pulse is matched against the queues
    always @(negedge clk) begin
        trig_t e;
        if (rst_in) begin
            rel = cyc - t0;
            if (bus.trigger_out) begin
                trig_seen++;
                chk("trig_back_to_back", int'(prev_trig), 0);
                if (exp_trig.size() == 0) begin
                    chk("unexpected_trigger_cycle", rel, -1);
                end else begin
                    e = exp_trig.pop_front();
                    chk("trig_cycle", rel, e.cyc);
                    chk("trig_data", int'(bus.data_out), e.data);
                    chk("trig_hcount", int'(bus.hcount_out), e.h);
                    chk("trig_vcount", int'(bus.vcount_out), e.v);
                    chk("trig_hsync", int'(bus.spi_hsync_out), e.hs);
                    chk("trig_vsync", int'(bus.spi_vsync_out), e.vs);
                end
            end
            if (bus.frame_done_out) begin
                if (exp_done.size() == 0) chk("unexpected_done_cycle", rel, -1);
                else                      chk("done_cycle", rel, exp_done.pop_front());
            end
            if (bus.busy_out) chk("addr_in_frame", int'(bus.addr_out < 16'(H * V)), 1);
            prev_trig = bus.trigger_out;
        end
    end

    task automatic run_scenario(input int idx);
        scen_t s;
        int cutoff;
        s = scen[idx];
        cutoff = (s.abort_at < 0) ? 100000 : s.abort_at;
        push_frame(cutoff, s.cont);
        if (s.done_at >= 0) exp_done.push_back(s.done_at);
        trig_seen = 0;
        @(posedge clk); #1;
        t0 = cyc;
        for (int c = 0; c < s.len; c++) begin
            bus.start_in      = (c == 0) || (c == s.start2_at);
            bus.abort_in      = (c == s.abort_at);
            bus.continuous_in = s.cont;
            @(negedge clk);
            if (c == s.busy_fall - 1) chk({s.name, "_busy_before_end"}, int'(bus.busy_out), 1);
            if (c == s.busy_fall)     chk({s.name, "_busy_after_end"}, int'(bus.busy_out), 0);
            if (idx == 0) begin
                for (int p = 0; p < 11; p++) begin
                    if (probes[p].cyc == c) begin
                        chk("probe_busy", int'(bus.busy_out), probes[p].busy);
                        chk("probe_hsync", int'(bus.spi_hsync_out), probes[p].hs);
                        chk("probe_vsync", int'(bus.spi_vsync_out), probes[p].vs);
                        chk("probe_done", int'(bus.frame_done_out), probes[p].done);
                        if (probes[p].h >= 0) chk("probe_hcount", int'(bus.hcount_out), probes[p].h);
                        if (probes[p].v >= 0) chk("probe_vcount", int'(bus.vcount_out), probes[p].v);
                    end
                end
            end
            @(posedge clk); #1;
        end
        bus.start_in      = 1'b0;
        bus.abort_in      = 1'b0;
        bus.continuous_in = 1'b0;
        chk({s.name, "_trigger_count"}, trig_seen, s.n_trig);
        chk({s.name, "_pending_triggers"}, exp_trig.size(), 0);
        chk({s.name, "_pending_done"}, exp_done.size(), 0);
        chk({s.name, "_idle_at_end"}, int'(bus.busy_out), 0);
    endtask

    initial begin
        //         name        cont start2 abort len  ntrig done fall
        scen[0] = '{"frame",     0,  -1,   -1,  80,  8,   72,  73};
        scen[1] = '{"abort",     0,  -1,   14,  40,  2,   -1,  20};
        scen[2] = '{"ign_start", 0,  10,   -1,  80,  8,   72,  73};
        scen[3] = '{"cont",      1,  -1,   80,  95,  9,   72,  84};
        //           cyc busy hs vs done  h   v
        probes[0]  = '{3,  1, 0, 0, 0, -1, -1};
        probes[1]  = '{4,  1, 1, 1, 0,  0,  0};
        probes[2]  = '{11, 1, 1, 1, 0,  0,  0};
        probes[3]  = '{12, 1, 0, 0, 0,  1,  0};
        probes[4]  = '{28, 1, 0, 0, 0,  3,  0};
        probes[5]  = '{36, 1, 0, 0, 0, -1, -1};
        probes[6]  = '{40, 1, 1, 0, 0,  0,  1};
        probes[7]  = '{47, 1, 1, 0, 0,  0,  1};
        probes[8]  = '{48, 1, 0, 0, 0,  1,  1};
        probes[9]  = '{72, 1, 0, 0, 1, -1, -1};
        probes[10] = '{73, 0, 0, 0, 0, -1, -1};

        bus.start_in      = 1'b0;
        bus.abort_in      = 1'b0;
        bus.continuous_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(bus.busy_out), 0);
        chk("reset_trigger", int'(bus.trigger_out), 0);
        chk("reset_addr", int'(bus.addr_out), 0);
        chk("reset_data", int'(bus.data_out), 0);
        chk("reset_hcount", int'(bus.hcount_out), 0);
        @(negedge clk);
        rst_in = 1'b1;

        for (int i = 0; i < 4; i++) run_scenario(i);

        // start and abort together while idle: nothing may happen
        trig_seen = 0;
        @(posedge clk); #1;
        t0 = cyc;
        bus.start_in = 1'b1;
        bus.abort_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("start_abort_idle_busy", int'(bus.busy_out), 0);
        end
        chk("start_abort_idle_triggers", trig_seen, 0);

        // asynchronous reset in the middle of pixel (3,0)'s slot
        push_frame(29, 1'b0);
        trig_seen = 0;
        @(posedge clk); #1;
        t0 = cyc;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (29) @(posedge clk);
        #4;
        chk("pre_reset_triggers", trig_seen, 4);
        chk("pre_reset_busy", int'(bus.busy_out), 1);
        rst_in = 1'b0;
        #1;
        chk("async_rst_busy", int'(bus.busy_out), 0);
        chk("async_rst_trigger", int'(bus.trigger_out), 0);
        chk("async_rst_hsync", int'(bus.spi_hsync_out), 0);
        chk("async_rst_vsync", int'(bus.spi_vsync_out), 0);
        chk("async_rst_done", int'(bus.frame_done_out), 0);
        chk("async_rst_addr", int'(bus.addr_out), 0);
        chk("async_rst_data", int'(bus.data_out), 0);
        chk("async_rst_hcount", int'(bus.hcount_out), 0);
        chk("async_rst_vcount", int'(bus.vcount_out), 0);
        chk("async_rst_pending", exp_trig.size(), 0);
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        run_scenario(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
Sequences a full frame of pixels from a synchronous-read frame buffer into the 4-line SPI sender (spi_send_con).
- Generates buffer read addresses and fetches each pixel.
- Issues one-cycle triggers at a fixed pixel slot spacing, so the sender is never retriggered mid-shift.
- Drives the spi_hsync/spi_vsync framing lines for the receiving board.
- Sits between the frame BRAM and spi_send_con in top_level; replaces the switch-driven single-pixel trigger.

Parameters:
H_PIXELS, 320, pixels per row
V_PIXELS, 180, rows per frame
DATA_WIDTH, 8, pixel width; matches spi_send_con DATA_WIDTH
ADDR_WIDTH, 16, buffer address width; must satisfy 2^ADDR_WIDTH >= H_PIXELS*V_PIXELS
READ_LATENCY, 2, buffer cycles from addr_out to valid pixel_in
TX_CYCLES, 16, cycles per pixel slot (trigger-to-trigger); must be >= READ_LATENCY+2 and >= sender transfer time
LINE_GAP, 32, idle cycles inserted after each row's final slot

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
start_in  input  1  one-cycle pulse; begins a frame when idle
continuous_in  input  1  when high at frame end, the next frame starts automatically
abort_in  input  1  stop the frame after the current slot completes
addr_out  output  ADDR_WIDTH  frame buffer read address
pixel_in  input  DATA_WIDTH  buffer read data
data_out  output  DATA_WIDTH  to spi_send_con data_in
trigger_out  output  1  to spi_send_con trigger_in; one-cycle pulse
spi_hsync_out  output  1  high for the whole slot of pixel h=0 of every row
spi_vsync_out  output  1  high for the whole slot of pixel (0,0)
busy_out  output  1  high in any state other than IDLE
frame_done_out  output  1  one-cycle pulse at end of a completed frame
hcount_out  output  16  column of the pixel currently in its slot
vcount_out  output  16  row of the pixel currently in its slot

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; all outputs 0; address and pixel counters 0.
- States: IDLE, FETCH, SEND, HOLD, GAP, DRAIN.
- IDLE:
  - start_in=1 and abort_in=0 -> FETCH; addr_out=0 on the next cycle.
  - start_in is ignored while busy_out=1.
  - start_in and abort_in high together in IDLE -> stay IDLE.
- FETCH (first pixel of frame only):
  - Wait READ_LATENCY cycles, then sample pixel_in.
  - Next cycle enter SEND.
  - First trigger_out occurs READ_LATENCY+2 cycles after the cycle start_in is sampled.
- SEND (1 cycle):
  - trigger_out=1; data_out=captured pixel.
  - hcount/vcount update to that pixel.
  - hsync/vsync rise this cycle and stay high through the slot.
- HOLD (TX_CYCLES-1 cycles):
  - Prefetch: the cycle after SEND, addr_out advances to the next linear address (v*H_PIXELS+h, incrementing).
  - pixel_in is captured READ_LATENCY cycles later into a holding register.
  - data_out holds its value throughout.
  - At the end of HOLD:
    - next pixel in same row -> SEND
    - row complete and not last row -> GAP
    - last pixel of frame -> DRAIN
- GAP (LINE_GAP cycles): trigger_out=0, syncs=0, then SEND for h=0 of the next row.
  - Row-to-row trigger spacing = TX_CYCLES+LINE_GAP.
- DRAIN (1 cycle): frame_done_out=1; addr_out wraps to 0.
  - continuous_in=1 -> GAP, then FETCH-free SEND of pixel (0,0); the pixel is prefetched during GAP.
  - Otherwise -> IDLE.
- abort_in, sampled in any busy state:
  - Latched.
  - Current slot's HOLD completes (or GAP ends immediately).
  - Then IDLE.
  - No further triggers; frame_done_out not pulsed.
- trigger_out is never high on consecutive cycles. Minimum spacing is TX_CYCLES.
- Counters wrap: h at H_PIXELS-1 -> 0 with v+1; v at V_PIXELS-1 -> 0 at frame end.
- Reset mid-frame: immediate return to all-zero outputs. Sender recovery is the sender's concern.

Test Plan:
All scenarios use H=4, V=2, RL=2, TX=8, GAP=4, buffer contents = address+0x10.
- Frame timing: start_in pulse at cycle 0 -> trigger_out exactly at cycles 4, 12, 20, 28, 40, 48, 56, 64 with data_out 0x10..0x17; frame_done_out at cycle 72 only; busy_out low at 73.
- Framing lines: spi_vsync_out high cycles 4-11 only; spi_hsync_out high cycles 4-11 and 40-47; hcount/vcount = (3,0) at cycle 28, (0,1) at cycle 40.
- Continuous mode: continuous_in=1 -> second frame's (0,0) trigger at cycle 76 with data 0x10 and vsync high; addr wraps cleanly.
- Abort: abort_in pulse at cycle 14 -> no trigger at 20 or later; busy_out falls after slot end (cycle 20); frame_done_out never asserted; a new start_in then gives first trigger RL+2 cycles later.
- Ignored/simultaneous: start_in at cycle 10 mid-frame -> timing identical to scenario 1; start_in+abort_in together in IDLE -> no activity.
- Async reset: rst_in low at cycle 30 (not clock-aligned) -> all outputs 0 immediately; restart after release behaves as scenario 1.
